adder_sum_accumulator: RTL and testbench

Block-sum accumulator that sits directly downstream of the pipelined 8-bit adder and consumes its 9-bit sum stream. It adds a programmable number of valid sums into a running total, then presents the block total on a valid/ready output port. Accumulation runs independently of output consumption. An overrun flag reports a completed block that could not be delivered because the previous total was still unconsumed. The adder cannot stall, so this block never back-pressures its input.

---
 rtl/adder_sum_accumulator_if.sv | 24 ++
 rtl/adder_sum_accumulator.sv | 85 ++++++++
 tb/tb_adder_sum_accumulator.sv | 127 ++++++++++++
 3 files changed

// File: rtl/adder_sum_accumulator_if.sv
// Sum-stream input and block-total output bundle for adder_sum_accumulator.
// master drives samples and consumes totals; slave is the accumulator itself.
interface adder_sum_accumulator_if #(
  parameter int SUM_W = 9,
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic [SUM_W-1:0] in_sum;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic             overrun;

  modport master (
    output in_valid, in_sum, clear, out_ready,
    input  out_valid, out_total, overrun
  );

  modport slave (
    input  in_valid, in_sum, clear, out_ready,
    output out_valid, out_total, overrun
  );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Sums COUNT valid adder results per block and offers each block total on a
// valid/ready port; a total that finds the output still occupied sets overrun.
module adder_sum_accumulator #(
  parameter int SUM_W = 9,
  parameter int COUNT = 8,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  adder_sum_accumulator_if.slave  bus
);
  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] out_total_q, out_total_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  logic             take;
  logic             complete;
  logic             handshake;
  logic [ACC_W-1:0] next_total;

  assign take       = bus.in_valid && !bus.clear;
  assign complete   = take && (cnt_q == LAST);
  assign handshake  = out_valid_q && bus.out_ready;
  assign next_total = acc_q + ACC_W'(bus.in_sum);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_total_d = out_total_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    // clear suppresses the sample, so it can never coincide with a completion
    if (bus.clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (complete) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (take) begin
      acc_d = next_total;
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (complete) begin
      if (!out_valid_q || handshake) begin
        out_total_d = next_total;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end

    if (bus.clear) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_total_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_total_q <= out_total_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_total = out_total_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator: fixed sample sequences with
// hand-computed block totals, checked by immediate assertions.
module tb_adder_sum_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  adder_sum_accumulator_if #(.SUM_W(9), .ACC_W(16)) bus_if ();

  adder_sum_accumulator #(.SUM_W(9), .COUNT(8), .ACC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] t, input logic o);
    check({tag, ".out_valid"}, 32'(bus_if.out_valid), 32'(v));
    check({tag, ".out_total"}, 32'(bus_if.out_total), 32'(t));
    check({tag, ".overrun"},   32'(bus_if.overrun),   32'(o));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic v, input logic [8:0] s, input logic c, input logic r);
    bus_if.in_valid  = v;
    bus_if.in_sum    = s;
    bus_if.clear     = c;
    bus_if.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic samples(input int n, input logic [8:0] s, input logic r);
    for (int i = 0; i < n; i++) cycle(1'b1, s, 1'b0, r);
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_sum    = '0;
    bus_if.clear     = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;

    // Full-scale block, consumer always ready
    samples(7, 9'h1FF, 1'b1);
    check("full.before_8th", 32'(bus_if.out_valid), 32'd0);
    samples(1, 9'h1FF, 1'b1);
    check_out("full.after_8th", 1'b1, 16'h0FF8, 1'b0);
    cycle(1'b0, 9'h000, 1'b0, 1'b1);
    check_out("full.consumed", 1'b0, 16'h0FF8, 1'b0);

    // Gapped input 1..8, two idle cycles after each sample
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b1, 9'(k), 1'b0, 1'b1);
      cycle(1'b0, 9'h000, 1'b0, 1'b1);
      cycle(1'b0, 9'h000, 1'b0, 1'b1);
    end
    check("gap.before_8th", 32'(bus_if.out_valid), 32'd0);
    cycle(1'b1, 9'd8, 1'b0, 1'b1);
    check_out("gap.after_8th", 1'b1, 16'h0024, 1'b0);
    cycle(1'b0, 9'h000, 1'b0, 1'b1);
    check("gap.consumed", 32'(bus_if.out_valid), 32'd0);

    // Back-pressure overrun
    samples(8, 9'd1, 1'b0);
    check_out("ovr.block1", 1'b1, 16'h0008, 1'b0);
    samples(7, 9'd2, 1'b0);
    check("ovr.before_block2_end", 32'(bus_if.overrun), 32'd0);
    samples(1, 9'd2, 1'b0);
    check_out("ovr.block2_dropped", 1'b1, 16'h0008, 1'b1);
    cycle(1'b0, 9'h000, 1'b0, 1'b1);
    check_out("ovr.after_handshake", 1'b0, 16'h0008, 1'b1);
    cycle(1'b0, 9'h000, 1'b1, 1'b0);
    check("ovr.cleared", 32'(bus_if.overrun), 32'd0);

    // Handshake and completion in the same cycle
    samples(8, 9'd1, 1'b0);
    check_out("simul.pending", 1'b1, 16'h0008, 1'b0);
    samples(7, 9'd3, 1'b0);
    samples(1, 9'd3, 1'b1);
    check_out("simul.reloaded", 1'b1, 16'h0018, 1'b0);
    cycle(1'b0, 9'h000, 1'b0, 1'b1);
    check("simul.consumed", 32'(bus_if.out_valid), 32'd0);

    // Clear mid-block discards partial sum and the coincident sample
    samples(3, 9'd5, 1'b0);
    cycle(1'b1, 9'd7, 1'b1, 1'b0);
    samples(7, 9'd1, 1'b0);
    check("clr.before_8th", 32'(bus_if.out_valid), 32'd0);
    samples(1, 9'd1, 1'b0);
    check_out("clr.total", 1'b1, 16'h0008, 1'b0);
    cycle(1'b0, 9'h000, 1'b0, 1'b1);
    check("clr.consumed", 32'(bus_if.out_valid), 32'd0);

    // Async reset mid-block with a pending total and overrun set
    samples(16, 9'd4, 1'b0);
    check_out("arst.pending", 1'b1, 16'h0020, 1'b1);
    samples(5, 9'd9, 1'b0);
    bus_if.in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_out("arst.immediate", 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    samples(7, 9'd2, 1'b0);
    check("arst.before_8th", 32'(bus_if.out_valid), 32'd0);
    samples(1, 9'd2, 1'b0);
    check_out("arst.new_block", 1'b1, 16'h0010, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
